// File: rtl/rtype_pkg.sv
// Shared encodings, state type and helpers for the R-type issue path.
// Everything here is a constant or a pure function.
package rtype_pkg;

    localparam logic [5:0] OPCODE_R    = 6'b000000;

    localparam logic [5:0] FUNCT_SLL   = 6'd0;
    localparam logic [5:0] FUNCT_SRL   = 6'd2;
    localparam logic [5:0] FUNCT_SRA   = 6'd3;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_ADDU  = 6'd33;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } issue_state_t;

    function automatic logic [31:0] encode_rtype(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] shamt,
        input logic [5:0] funct
    );
        return {OPCODE_R, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic is_legal_funct(input logic [5:0] funct);
        logic legal;
        case (funct)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
            FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB,
            FUNCT_AND, FUNCT_OR, FUNCT_SLTU: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rtype_fifo.sv
// Word FIFO holding encoded instructions plus their rd field.
// Push is ignored when full, pop is ignored when empty.
module rtype_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_word,
    input  logic [4:0]  push_rd,
    input  logic        pop,
    output logic [31:0] pop_word,
    output logic [4:0]  pop_rd,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   word_mem [DEPTH];
    logic [4:0]    rd_mem   [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_word = word_mem[rd_ptr_q];
    assign pop_rd   = rd_mem[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            word_mem[wr_ptr_q] <= push_word;
            rd_mem[wr_ptr_q]   <= push_rd;
        end
    end

endmodule

// File: rtl/rtype_issue_unit.sv
// Encodes R-type requests, queues them, issues one at a time to the core
// and returns the core result tagged with rd after EXEC_LAT cycles.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued word
//   ISSUE | pop head, drive instr_out, load wait counter
//   WAIT  | count down EXEC_LAT, capture result at zero
//   DONE  | present res_valid, then issue next or idle
module rtype_issue_unit
    import rtype_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int EXEC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic [31:0] core_result,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        err_illegal,
    output logic [15:0] issue_count
);

    issue_state_t state_q, state_d;
    logic [31:0]  instr_out_q, instr_out_d;
    logic         instr_valid_q, instr_valid_d;
    logic         res_valid_q, res_valid_d;
    logic [31:0]  res_data_q, res_data_d;
    logic [4:0]   res_rd_q, res_rd_d;
    logic         err_illegal_q, err_illegal_d;
    logic [15:0]  issue_count_q, issue_count_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic [4:0]   flight_rd_q, flight_rd_d;

    logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [31:0]  fifo_word;
    logic [4:0]   fifo_rd;
    logic         accept, funct_ok;

    assign in_ready = !fifo_full && !rst;
    assign accept   = in_valid && in_ready;
    assign funct_ok = is_legal_funct(in_funct);
    assign fifo_push = accept && funct_ok;

    rtype_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_word (encode_rtype(in_rs, in_rt, in_rd, in_shamt, in_funct)),
        .push_rd   (in_rd),
        .pop       (fifo_pop),
        .pop_word  (fifo_word),
        .pop_rd    (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        instr_out_d   = instr_out_q;
        instr_valid_d = 1'b0;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        res_rd_d      = res_rd_q;
        issue_count_d = issue_count_q;
        wait_cnt_d    = wait_cnt_q;
        flight_rd_d   = flight_rd_q;
        fifo_pop      = 1'b0;
        err_illegal_d = accept && !funct_ok;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fifo_pop      = 1'b1;
                instr_out_d   = fifo_word;
                instr_valid_d = 1'b1;
                flight_rd_d   = fifo_rd;
                wait_cnt_d    = 4'(EXEC_LAT);
                issue_count_d = issue_count_q + 16'd1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    res_data_d = core_result;
                    res_rd_d   = flight_rd_q;
                    state_d    = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DONE: begin
                res_valid_d = 1'b1;
                state_d     = fifo_empty ? IDLE : ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            err_illegal_q <= 1'b0;
            issue_count_q <= '0;
            wait_cnt_q    <= '0;
            flight_rd_q   <= '0;
        end else begin
            state_q       <= state_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_rd_q      <= res_rd_d;
            err_illegal_q <= err_illegal_d;
            issue_count_q <= issue_count_d;
            wait_cnt_q    <= wait_cnt_d;
            flight_rd_q   <= flight_rd_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign err_illegal = err_illegal_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Directed bench for rtype_issue_unit: encoding, ordering, backpressure,
// illegal funct, reset mid-flight and issue_count wrap.
module tb_rtype_issue_unit;

    localparam int DEPTH = 4;
    localparam int L     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] core_result = '0;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        err_illegal;
    logic [15:0] issue_count;

    int checks = 0;
    int passed = 0;

    logic [31:0] iss_q[$];
    logic [4:0]  rd_q[$];
    int          res_seen = 0;

    always #5 clk = ~clk;

    rtype_issue_unit #(.DEPTH(DEPTH), .EXEC_LAT(L)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_shamt    (in_shamt),
        .in_funct    (in_funct),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .err_illegal (err_illegal),
        .issue_count (issue_count)
    );

    always @(negedge clk) begin
        if (instr_valid) iss_q.push_back(instr_out);
        if (res_valid) begin
            rd_q.push_back(res_rd);
            res_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_rd", res_rd, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_issue_count", issue_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [5:0] fn);
        in_valid = 1'b1;
        in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_funct = fn;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // instr_valid at cycle v, res_valid exactly at v+L+2 for one cycle.
    task automatic expect_issue(input logic [31:0] word, input logic [4:0] rd, input logic [31:0] result);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_seen", instr_valid, 1);
        chk("instr_out", instr_out, word);
        @(negedge clk);
        chk("instr_valid_pulse", instr_valid, 0);
        for (int i = 0; i <= L; i++) begin
            chk("res_valid_early", res_valid, 0);
            @(negedge clk);
        end
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, result);
        chk("res_rd", res_rd, rd);
        @(negedge clk);
        chk("res_valid_pulse", res_valid, 0);
    endtask

    initial begin
        int base, rbase, n, k, stalls, first_stall_k;
        logic acc;
        logic [31:0] w;

        // 1: basic add
        do_reset();
        core_result = 32'h1234_5678;
        push(5'd1, 5'd2, 5'd3, 5'd0, 6'd32);
        expect_issue(32'h0022_1820, 5'd3, 32'h1234_5678);
        chk("count_after_1", issue_count, 1);

        // 2: sll then sltu, in order
        do_reset();
        core_result = 32'hCAFE_0002;
        push(5'd0, 5'd4, 5'd5, 5'd8, 6'd0);
        push(5'd7, 5'd8, 5'd9, 5'd0, 6'd43);
        expect_issue(32'h0004_2A00, 5'd5, 32'hCAFE_0002);
        expect_issue(32'h00E8_482B, 5'd9, 32'hCAFE_0002);
        chk("count_after_2", issue_count, 2);

        // 3: six back-to-back requests against a 4-deep FIFO
        do_reset();
        base = iss_q.size();
        rbase = rd_q.size();
        k = 0; n = 0; stalls = 0; first_stall_k = -1;
        while (k < 6 && n < 100) begin
            in_valid = 1'b1;
            in_rs = 5'(k); in_rt = 5'(k + 1); in_rd = 5'(k + 10);
            in_shamt = 5'd0; in_funct = 6'd33;
            acc = in_ready;
            if (!acc) begin
                stalls++;
                if (first_stall_k < 0) first_stall_k = k;
            end
            @(negedge clk);
            if (acc) k++;
            n++;
        end
        in_valid = 1'b0;
        chk("fill_all_accepted", 32'(k), 6);
        chk("fill_first_stall", 32'(first_stall_k), 5);
        chk("fill_stall_cycles", 32'(stalls), 2);
        n = 0;
        while ((iss_q.size() < base + 6 || rd_q.size() < rbase + 6) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("fill_issued", 32'(iss_q.size() - base), 6);
        chk("fill_results", 32'(rd_q.size() - rbase), 6);
        for (int i = 0; i < 6; i++) begin
            w = {6'b0, 5'(i), 5'(i + 1), 5'(i + 10), 5'd0, 6'd33};
            if (base + i < iss_q.size()) chk("fill_order_word", iss_q[base + i], w);
            if (rbase + i < rd_q.size()) chk("fill_order_rd", 32'(rd_q[rbase + i]), 32'(i + 10));
        end
        chk("fill_count", issue_count, 6);

        // 4: illegal funct is dropped
        base = iss_q.size();
        in_valid = 1'b1;
        in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_shamt = 5'd0; in_funct = 6'd8;
        @(negedge clk);
        in_valid = 1'b0;
        chk("illegal_err", err_illegal, 1);
        @(negedge clk);
        chk("illegal_err_pulse", err_illegal, 0);
        repeat (6) @(negedge clk);
        chk("illegal_no_issue", 32'(iss_q.size() - base), 0);
        chk("illegal_count", issue_count, 6);
        core_result = 32'h0000_00A7;
        push(5'd0, 5'd6, 5'd7, 5'd1, 6'd2);
        expect_issue(32'h0006_3842, 5'd7, 32'h0000_00A7);

        // 5: reset while waiting on the core
        core_result = 32'hBAD0_BAD0;
        push(5'd1, 5'd1, 5'd1, 5'd0, 6'd37);
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_issue", instr_out, 32'h0021_0825);
        rst = 1'b1;
        #1;
        chk("rst_cycle_in_ready", in_ready, 0);
        do_reset();
        base = res_seen;
        repeat (6) @(negedge clk);
        chk("rst_no_res_valid", 32'(res_seen - base), 0);
        core_result = 32'h5555_AAAA;
        push(5'd2, 5'd3, 5'd4, 5'd0, 6'd34);
        expect_issue(32'h0043_2022, 5'd4, 32'h5555_AAAA);
        chk("rst_count", issue_count, 1);

        // 6: issue_count wraps
        force u_dut.issue_count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut.issue_count_q;
        @(negedge clk);
        chk("wrap_preload", issue_count, 32'h0000_FFFF);
        core_result = 32'h0F0F_F0F0;
        push(5'd31, 5'd31, 5'd31, 5'd31, 6'd3);
        expect_issue(32'h03FF_FFC3, 5'd31, 32'h0F0F_F0F0);
        chk("wrap_count", issue_count, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
